// File: rtl/i2c_slave_reg_rx.sv
// rtl/i2c_slave_reg_rx.sv - write-only I2C responder turning received data bytes into register-write strobes
module i2c_slave_reg_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oWR_EN,
    output logic [7:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oBUSY
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, SUB, ACK_S, DATA, ACK_D, IGNORE
    } state_t;

    state_t state, nextState;

    logic [SYNC_STAGES-1:0] sclSync, sdaSync;
    logic                   sclHist, sdaHist;
    logic [SYNC_STAGES:0]   settle;
    logic                   sclS, sdaS, armed;
    logic                   sclRise, sclFall, startEv, stopEv;
    logic [2:0]             bitCnt;
    logic [7:0]             shiftReg, byteVal, pointer;
    logic                   byteDone, addrMatch, inAck, inRecv;
    logic                   ackPhase, sdaLow;

    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

    assign sclS  = sclSync[SYNC_STAGES-1];
    assign sdaS  = sdaSync[SYNC_STAGES-1];
    // Events stay masked until the pipeline has refilled after reset, so a
    // reset released mid-frame cannot fake a START from the idle-high flops.
    assign armed = settle[SYNC_STAGES];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sclSync <= '1;
            sdaSync <= '1;
            sclHist <= 1'b1;
            sdaHist <= 1'b1;
            settle  <= '0;
        end else begin
            sclSync <= {sclSync[SYNC_STAGES-2:0], I2C_SCLK};
            sdaSync <= {sdaSync[SYNC_STAGES-2:0], I2C_SDAT};
            sclHist <= sclS;
            sdaHist <= sdaS;
            settle  <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclRise   = armed & ~sclHist & sclS;
    assign sclFall   = armed & sclHist & ~sclS;
    assign startEv   = armed & sclS & sdaHist & ~sdaS;
    assign stopEv    = armed & sclS & ~sdaHist & sdaS;
    assign byteDone  = sclRise & (bitCnt == 3'd7);
    assign byteVal   = {shiftReg[6:0], sdaS};
    assign addrMatch = (byteVal[7:1] == DEV_ADDR) & ~byteVal[0];
    assign inAck     = (state == ACK_A) | (state == ACK_S) | (state == ACK_D);
    assign inRecv    = (state == ADDR) | (state == SUB) | (state == DATA);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (startEv) begin
            nextState = ADDR;
        end else if (stopEv) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:   nextState = IDLE;
                ADDR:   if (byteDone) nextState = addrMatch ? ACK_A : IGNORE;
                ACK_A:  if (sclFall && ackPhase) nextState = SUB;
                SUB:    if (byteDone) nextState = ACK_S;
                ACK_S:  if (sclFall && ackPhase) nextState = DATA;
                DATA:   if (byteDone) nextState = ACK_D;
                ACK_D:  if (sclFall && ackPhase) nextState = DATA;
                IGNORE: nextState = IGNORE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bitCnt   <= '0;
            shiftReg <= '0;
            pointer  <= '0;
            ackPhase <= 1'b0;
            sdaLow   <= 1'b0;
            oWR_EN   <= 1'b0;
            oWR_ADDR <= '0;
            oWR_DATA <= '0;
            oBUSY    <= 1'b0;
        end else begin
            oWR_EN <= 1'b0;
            if (startEv || stopEv) begin
                bitCnt   <= '0;
                sdaLow   <= 1'b0;
                ackPhase <= 1'b0;
                if (stopEv) oBUSY <= 1'b0;
            end else begin
                if (sclRise && inRecv) begin
                    shiftReg <= byteVal;
                    bitCnt   <= bitCnt + 3'd1;
                end
                // First fall after the byte pulls SDA low, the next one lets go.
                if (inAck && sclFall) begin
                    sdaLow   <= ~ackPhase;
                    ackPhase <= ~ackPhase;
                end
                if (byteDone) begin
                    case (state)
                        ADDR: oBUSY <= addrMatch;
                        SUB:  pointer <= byteVal;
                        DATA: begin
                            oWR_EN   <= 1'b1;
                            oWR_ADDR <= pointer;
                            oWR_DATA <= byteVal;
                            pointer  <= pointer + 8'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_rx.sv
// tb/tb_i2c_slave_reg_rx.sv - scoreboard bench for i2c_slave_reg_rx
module tb_i2c_slave_reg_rx;

    logic       iCLK   = 1'b0;
    logic       iRST   = 1'b1;
    logic       scl    = 1'b1;
    logic       mstLow = 1'b0;
    wire        sda;
    logic       wrEn;
    logic [7:0] wrAddr, wrData;
    logic       busy;

    int          checks   = 0;
    int          errors   = 0;
    logic [15:0] expQ[$];
    logic        prevEn   = 1'b0;
    logic        busySeen = 1'b0;

    pullup (sda);
    assign sda = mstLow ? 1'b0 : 1'bz;

    i2c_slave_reg_rx #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .oWR_EN   (wrEn),
        .oWR_ADDR (wrAddr),
        .oWR_DATA (wrData),
        .oBUSY    (busy)
    );

    always #10 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        logic [15:0] exp;
        if (wrEn) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got addr=%h data=%h required none", wrAddr, wrData);
            end else begin
                exp = expQ.pop_front();
                if ({wrAddr, wrData} !== exp) begin
                    errors++;
                    $display("FAIL strobe got addr=%h data=%h required addr=%h data=%h",
                             wrAddr, wrData, exp[15:8], exp[7:0]);
                end
            end
            checks++;
            if (prevEn) begin
                errors++;
                $display("FAIL strobe_width got 2+ cycles required 1");
            end
        end
        prevEn = wrEn;
        if (busy) busySeen = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        cyc(3); mstLow = ~b;
        cyc(7); scl = 1'b1;
        cyc(10); scl = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) sendBit(b[7-i]);
    endtask

    task automatic ackSlot(input string name, input logic expAck);
        cyc(3); mstLow = 1'b0;
        cyc(7); scl = 1'b1;
        cyc(5); check(name, sda, expAck ? 1'b0 : 1'b1);
        cyc(5); scl = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic expAck, input string name);
        sendBits(b, 8);
        ackSlot(name, expAck);
    endtask

    task automatic i2cStart();
        cyc(3); mstLow = 1'b0;
        cyc(7); scl = 1'b1;
        cyc(10); mstLow = 1'b1;
        cyc(10); scl = 1'b0;
    endtask

    task automatic i2cStop(input logic chkBusy);
        cyc(3); mstLow = 1'b1;
        cyc(7); scl = 1'b1;
        cyc(10); mstLow = 1'b0;
        if (chkBusy) begin
            cyc(2); check("busy_before_stop_latency", busy, 1'b1);
            cyc(1); check("busy_after_stop_latency", busy, 1'b0);
            cyc(7);
        end else begin
            cyc(10);
        end
    endtask

    initial begin
        cyc(5);
        check("rst_wr_en", wrEn, 1'b0);
        check("rst_wr_addr", wrAddr, 8'h00);
        check("rst_wr_data", wrData, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda, 1'b1);
        iRST = 1'b0;
        cyc(10);

        expQ.push_back({8'h0C, 8'h00});
        i2cStart();
        sendByte(8'h34, 1'b1, "single_ack_addr");
        check("single_busy", busy, 1'b1);
        sendByte(8'h0C, 1'b1, "single_ack_sub");
        sendByte(8'h00, 1'b1, "single_ack_data");
        i2cStop(1'b1);
        cyc(20);

        busySeen = 1'b0;
        i2cStart();
        sendByte(8'h40, 1'b0, "mismatch_nack_addr");
        sendByte(8'h0C, 1'b0, "mismatch_nack_sub");
        sendByte(8'h55, 1'b0, "mismatch_nack_data");
        i2cStop(1'b0);
        check("mismatch_busy_never", busySeen, 1'b0);

        busySeen = 1'b0;
        i2cStart();
        sendByte(8'h35, 1'b0, "read_nack");
        i2cStop(1'b0);
        check("read_busy_never", busySeen, 1'b0);
        cyc(20);

        expQ.push_back({8'hFE, 8'h11});
        expQ.push_back({8'hFF, 8'h22});
        expQ.push_back({8'h00, 8'h33});
        i2cStart();
        sendByte(8'h34, 1'b1, "burst_ack_addr");
        sendByte(8'hFE, 1'b1, "burst_ack_sub");
        sendByte(8'h11, 1'b1, "burst_ack_d0");
        sendByte(8'h22, 1'b1, "burst_ack_d1");
        sendByte(8'h33, 1'b1, "burst_ack_d2");
        i2cStop(1'b0);
        cyc(20);

        expQ.push_back({8'h10, 8'h02});
        expQ.push_back({8'h20, 8'hA5});
        i2cStart();
        sendByte(8'h34, 1'b1, "rs_ack_addr0");
        sendByte(8'h10, 1'b1, "rs_ack_sub0");
        sendByte(8'h02, 1'b1, "rs_ack_data0");
        i2cStart();
        sendByte(8'h34, 1'b1, "rs_ack_addr1");
        sendByte(8'h20, 1'b1, "rs_ack_sub1");
        sendByte(8'hA5, 1'b1, "rs_ack_data1");
        i2cStop(1'b0);
        cyc(20);

        expQ.push_back({8'h40, 8'h66});
        i2cStart();
        sendByte(8'h34, 1'b1, "part_ack_addr0");
        sendByte(8'h30, 1'b1, "part_ack_sub0");
        sendBits(8'h99, 4);
        i2cStart();
        sendByte(8'h34, 1'b1, "part_ack_addr1");
        sendByte(8'h40, 1'b1, "part_ack_sub1");
        sendByte(8'h66, 1'b1, "part_ack_data1");
        i2cStop(1'b0);
        cyc(20);

        i2cStart();
        sendByte(8'h34, 1'b1, "rstmid_ack_addr");
        sendByte(8'h05, 1'b1, "rstmid_ack_sub");
        sendBits(8'hCB, 4);
        cyc(3); mstLow = 1'b0;
        cyc(7); scl = 1'b1;
        cyc(3); iRST = 1'b1;
        cyc(1);
        check("rstmid_sda", sda, 1'b1);
        check("rstmid_wr_en", wrEn, 1'b0);
        check("rstmid_wr_addr", wrAddr, 8'h00);
        check("rstmid_wr_data", wrData, 8'h00);
        check("rstmid_busy", busy, 1'b0);
        cyc(2); iRST = 1'b0;
        cyc(4); scl = 1'b0;
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        ackSlot("rstmid_nack_rest", 1'b0);
        i2cStop(1'b0);
        cyc(20);

        expQ.push_back({8'h01, 8'h7F});
        i2cStart();
        sendByte(8'h34, 1'b1, "post_ack_addr");
        sendByte(8'h01, 1'b1, "post_ack_sub");
        sendByte(8'h7F, 1'b1, "post_ack_data");
        i2cStop(1'b1);
        cyc(20);

        check("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
